// File: rtl/ec_pkg.sv
// Shared types for the elliptic-curve point unit: FSM states, add/double mode
// and multiplier operand-select codes.
package ec_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLASSIFY,
    ST_NUM,
    ST_DEN,
    ST_INV,
    ST_LAMBDA,
    ST_X3,
    ST_Y3,
    ST_DONE
  } state_t;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_DBL = 1'b1
  } mode_t;

  typedef enum logic [2:0] {
    SEL_X1_X1,
    SEL_ACC_ACC,
    SEL_ACC_DEN,
    SEL_NUM_ACC,
    SEL_LAM_LAM,
    SEL_LAM_DX
  } mul_sel_t;

endpackage

// File: rtl/mod_mul_serial.sv
// Bit-serial modular multiplier r = a*b mod p: MSB-first interleaved
// double-and-add, one bit of b per cycle, load cycle plus N iterations.
module mod_mul_serial #(
  parameter int N     = 256,
  parameter int CNT_W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] p,
  output logic [N-1:0] r,
  output logic         done
);

  logic [N-1:0]     a_q, b_q, p_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic [N+1:0]     acc_2x, acc_s1;
  logic [N-1:0]     acc_s2;

  // 2*acc + a stays below 3p, so two conditional subtracts restore [0, p).
  // NOTE: combinational blocks use blocking '=' and assign every output a value on every path, so no latch is inferred.
  always_comb begin
    acc_2x = {1'b0, r, 1'b0} + (b_q[N-1] ? {2'b00, a_q} : '0);
    acc_s1 = (acc_2x >= {2'b00, p_q}) ? acc_2x - {2'b00, p_q} : acc_2x;
    acc_s2 = (acc_s1 >= {2'b00, p_q}) ? N'(acc_s1 - {2'b00, p_q}) : N'(acc_s1);
  end

  // NOTE: every register, datapath included, is cleared by the async reset so an aborted operation leaves no residue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      r     <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_q   <= a;
        b_q   <= b;
        p_q   <= p;
        r     <= '0;
        cnt_q <= CNT_W'(N);
        run_q <= 1'b1;
      end else if (run_q) begin
        r     <= acc_s2;
        b_q   <= {b_q[N-2:0], 1'b0};
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          run_q <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ec_point_unit.sv
// Affine point adder/doubler R = P1 + P2 on y^2 = x^3 + a*x + b mod p, built
// around one serial multiplier. Optional input range check: EC_RANGE_CHECK_EN.
module ec_point_unit
  import ec_pkg::*;
#(
  parameter int N     = 256,
  parameter int CNT_W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] p,
  input  logic [N-1:0] a,
  input  logic [N-1:0] x1,
  input  logic [N-1:0] y1,
  input  logic         inf1,
  input  logic [N-1:0] x2,
  input  logic [N-1:0] y2,
  input  logic         inf2,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] x3,
  output logic [N-1:0] y3,
  output logic         inf3
`ifdef EC_RANGE_CHECK_EN
  ,
  output logic         err
`endif
);

  function automatic logic [N-1:0] mod_add(input logic [N-1:0] u, v, m);
    logic [N:0] s;
    s = {1'b0, u} + {1'b0, v};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[N-1:0];
  endfunction

  function automatic logic [N-1:0] mod_sub(input logic [N-1:0] u, v, m);
    logic [N:0] d;
    d = {1'b0, u} - {1'b0, v};
    if (d[N]) d = d + {1'b0, m};
    return d[N-1:0];
  endfunction

  state_t           state_q, state_d;
  mode_t            mode_q;
  mul_sel_t         mul_sel;
  logic [N-1:0]     p_q, a_q, x1_q, y1_q, x2_q, y2_q;
  logic             inf1_q, inf2_q;
  logic [N-1:0]     num_q, den_q, acc_q, lam_q, exp_q, res_x_q, res_y_q;
  logic             res_inf_q, issued_q, mul_step_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mul_start, mul_done;
  logic [N-1:0]     mul_a, mul_b, mul_r;
  logic [N-1:0]     num_dbl, x3_new, y3_new, dx3;
  logic             eq_x, neg_y, trivial, inv_mul_next, inv_last;

  assign busy    = (state_q != ST_IDLE);
  assign eq_x    = (x1_q == x2_q);
  assign neg_y   = (mod_add(y1_q, y2_q, p_q) == '0);
  assign num_dbl = mod_add(mod_add(mod_add(mul_r, mul_r, p_q), mul_r, p_q), a_q, p_q);
  assign x3_new  = mod_sub(mod_sub(mul_r, x1_q, p_q), x2_q, p_q);
  assign dx3     = mod_sub(x1_q, res_x_q, p_q);
  assign y3_new  = mod_sub(mul_r, y1_q, p_q);

  // After each squaring, a set exponent bit inserts one multiply by den.
  assign inv_mul_next = !mul_step_q && exp_q[N-1];
  assign inv_last     = !inv_mul_next && (cnt_q == '0);

`ifdef EC_RANGE_CHECK_EN
  logic range_bad;
  assign range_bad = !p_q[0] || (a_q >= p_q) ||
                     (!inf1_q && ((x1_q >= p_q) || (y1_q >= p_q))) ||
                     (!inf2_q && ((x2_q >= p_q) || (y2_q >= p_q)));
  assign trivial   = range_bad || inf1_q || inf2_q || (eq_x && neg_y);
`else
  assign trivial   = inf1_q || inf2_q || (eq_x && neg_y);
`endif

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    mul_sel   = SEL_X1_X1;
    case (state_q)
      ST_IDLE:     if (start) state_d = ST_CLASSIFY;
      ST_CLASSIFY: state_d = trivial ? ST_DONE : ST_NUM;
      ST_NUM: begin
        if (mode_q == MODE_ADD) begin
          state_d = ST_DEN;
        end else begin
          mul_start = !issued_q;
          if (mul_done) state_d = ST_DEN;
        end
      end
      ST_DEN: state_d = ST_INV;
      ST_INV: begin
        mul_sel   = mul_step_q ? SEL_ACC_DEN : SEL_ACC_ACC;
        mul_start = !issued_q;
        if (mul_done && inv_last) state_d = ST_LAMBDA;
      end
      ST_LAMBDA: begin
        mul_sel   = SEL_NUM_ACC;
        mul_start = !issued_q;
        if (mul_done) state_d = ST_X3;
      end
      ST_X3: begin
        mul_sel   = SEL_LAM_LAM;
        mul_start = !issued_q;
        if (mul_done) state_d = ST_Y3;
      end
      ST_Y3: begin
        mul_sel   = SEL_LAM_DX;
        mul_start = !issued_q;
        if (mul_done) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mul_a = x1_q;
    mul_b = x1_q;
    case (mul_sel)
      SEL_ACC_ACC: begin mul_a = acc_q; mul_b = acc_q; end
      SEL_ACC_DEN: begin mul_a = acc_q; mul_b = den_q; end
      SEL_NUM_ACC: begin mul_a = num_q; mul_b = acc_q; end
      SEL_LAM_LAM: begin mul_a = lam_q; mul_b = lam_q; end
      SEL_LAM_DX:  begin mul_a = lam_q; mul_b = dx3;   end
      default:     ;
    endcase
  end

  mod_mul_serial #(.N(N), .CNT_W(CNT_W)) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .p     (p_q),
    .r     (mul_r),
    .done  (mul_done)
  );

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;   mode_q     <= MODE_ADD;
      p_q <= '0; a_q <= '0; x1_q <= '0; y1_q <= '0; x2_q <= '0; y2_q <= '0;
      inf1_q  <= 1'b0;      inf2_q     <= 1'b0;
      num_q <= '0; den_q <= '0; acc_q <= '0; lam_q <= '0; exp_q <= '0;
      res_x_q <= '0;        res_y_q    <= '0;   res_inf_q <= 1'b0;
      issued_q <= 1'b0;     mul_step_q <= 1'b0; cnt_q     <= '0;
      done <= 1'b0; x3 <= '0; y3 <= '0; inf3 <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      if (mul_start)     issued_q <= 1'b1;
      else if (mul_done) issued_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          p_q <= p; a_q <= a; x1_q <= x1; y1_q <= y1; x2_q <= x2; y2_q <= y2;
          inf1_q <= inf1; inf2_q <= inf2;
        end
        ST_CLASSIFY: begin
          mode_q    <= eq_x ? MODE_DBL : MODE_ADD;
          res_x_q   <= '0;
          res_y_q   <= '0;
          res_inf_q <= 1'b0;
          if (inf1_q && inf2_q)     res_inf_q <= 1'b1;
          else if (inf1_q)          begin res_x_q <= x2_q; res_y_q <= y2_q; end
          else if (inf2_q)          begin res_x_q <= x1_q; res_y_q <= y1_q; end
          else if (eq_x && neg_y)   res_inf_q <= 1'b1;
`ifdef EC_RANGE_CHECK_EN
          if (range_bad) begin
            res_x_q <= '0; res_y_q <= '0; res_inf_q <= 1'b1;
          end
`endif
        end
        ST_NUM: begin
          if (mode_q == MODE_ADD) num_q <= mod_sub(y2_q, y1_q, p_q);
          else if (mul_done)      num_q <= num_dbl;
        end
        ST_DEN: begin
          den_q      <= (mode_q == MODE_ADD) ? mod_sub(x2_q, x1_q, p_q) : mod_add(y1_q, y1_q, p_q);
          acc_q      <= N'(1);
          exp_q      <= p_q - N'(2);
          cnt_q      <= CNT_W'(N - 1);
          mul_step_q <= 1'b0;
        end
        ST_INV: if (mul_done) begin
          acc_q <= mul_r;
          if (inv_mul_next) begin
            mul_step_q <= 1'b1;
          end else begin
            mul_step_q <= 1'b0;
            exp_q      <= {exp_q[N-2:0], 1'b0};
            cnt_q      <= cnt_q - CNT_W'(1);
          end
        end
        ST_LAMBDA: if (mul_done) lam_q   <= mul_r;
        ST_X3:     if (mul_done) res_x_q <= x3_new;
        ST_Y3:     if (mul_done) res_y_q <= y3_new;
        ST_DONE: begin
          done <= 1'b1;
          x3   <= res_x_q;
          y3   <= res_y_q;
          inf3 <= res_inf_q;
        end
        default: ;
      endcase
    end
  end

`ifdef EC_RANGE_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    err <= 1'b0;
    else if (state_q == ST_IDLE && start)          err <= 1'b0;
    else if (state_q == ST_CLASSIFY && range_bad)  err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ec_point_unit.sv
// Self-checking bench for ec_point_unit at N=8: directed curve vectors,
// handshake/reset scenarios and randomized operations against a reference model.
module tb_ec_point_unit;

  localparam int N       = 8;
  localparam int CNT_W   = 4;
  localparam int MAX_LAT = (2*N+5)*(N+1)+8;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] p = '0, a = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
  logic         inf1 = 1'b0, inf2 = 1'b0;
  logic         busy, done, inf3;
  logic [N-1:0] x3, y3;
`ifdef EC_RANGE_CHECK_EN
  logic         err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int primes [10] = '{5, 7, 11, 13, 17, 97, 131, 199, 241, 251};

  always #5 clk = ~clk;

  ec_point_unit #(.N(N), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .p     (p),
    .a     (a),
    .x1    (x1),
    .y1    (y1),
    .inf1  (inf1),
    .x2    (x2),
    .y2    (y2),
    .inf2  (inf2),
    .busy  (busy),
    .done  (done),
    .x3    (x3),
    .y3    (y3),
    .inf3  (inf3)
`ifdef EC_RANGE_CHECK_EN
    ,
    .err   (err)
`endif
  );

  // Reference model: textbook affine group law with plain integer arithmetic.
  function automatic int md(input longint v, input int m);
    longint r;
    r = v % m;
    if (r < 0) r += m;
    return int'(r);
  endfunction

  function automatic int inv_bf(input int d, input int m);
    for (int i = 1; i < m; i++)
      if (md(longint'(d) * i, m) == 1) return i;
    return 0;
  endfunction

  task automatic ref_point(input int m, ca, ax, ay, input bit ai, input int bx, by, input bit bi,
                           output int rx, ry, output bit ri, output bit triv);
    int lam;
    rx = 0; ry = 0; ri = 1'b0; triv = 1'b1;
    if (ai && bi)                          ri = 1'b1;
    else if (ai)                           begin rx = bx; ry = by; end
    else if (bi)                           begin rx = ax; ry = ay; end
    else if (ax == bx && md(ay + by, m) == 0) ri = 1'b1;
    else begin
      triv = 1'b0;
      if (ax == bx) lam = md(longint'(md(3*ax*ax + ca, m)) * inv_bf(md(2*ay, m), m), m);
      else          lam = md(longint'(md(by - ay, m)) * inv_bf(md(bx - ax, m), m), m);
      rx = md(lam*lam - ax - bx, m);
      ry = md(longint'(lam) * (ax - rx) - ay, m);
    end
  endtask

  // Starts one operation and waits for done; lat counts negedges after the accepting edge.
  task automatic run_op(input int m, ca, ax, ay, input bit ai, input int bx, by, input bit bi,
                        output int lat, output bit timed_out, output bit busy_gap);
    @(negedge clk);
    p = N'(m); a = N'(ca); x1 = N'(ax); y1 = N'(ay); inf1 = ai;
    x2 = N'(bx); y2 = N'(by); inf2 = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; timed_out = 1'b0; busy_gap = 1'b0;
    while (done !== 1'b1) begin
      if (busy !== 1'b1) busy_gap = 1'b1;
      if (lat >= MAX_LAT + 20) begin timed_out = 1'b1; break; end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    n_cmp++;
    if ({busy, done, inf3, x3, y3} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b done=%b inf3=%b x3=%0d y3=%0d, want all 0", busy, done, inf3, x3, y3);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_double;
    int lat; bit to, bg;
    run_op(17, 2, 5, 1, 0, 5, 1, 0, lat, to, bg);
    n_cmp++;
    if (to || x3 !== N'(6) || y3 !== N'(3) || inf3 !== 1'b0) begin
      n_bad++;
      $display("FAIL double_5_1: got (%0d,%0d,inf=%b) timeout=%b, want (6,3,inf=0)", x3, y3, inf3, to);
    end
    n_cmp++;
    if (bg) begin n_bad++; $display("FAIL double_busy: busy dropped before done, want high throughout"); end
    n_cmp++;
    if (lat > MAX_LAT) begin n_bad++; $display("FAIL double_latency: got %0d, want <= %0d", lat, MAX_LAT); end
  endtask

  task automatic test_add;
    int lat; bit to, bg;
    run_op(17, 2, 5, 1, 0, 6, 3, 0, lat, to, bg);
    n_cmp++;
    if (to || x3 !== N'(10) || y3 !== N'(6) || inf3 !== 1'b0) begin
      n_bad++;
      $display("FAIL add_5_1_6_3: got (%0d,%0d,inf=%b) timeout=%b, want (10,6,inf=0)", x3, y3, inf3, to);
    end
  endtask

  task automatic test_trivial;
    int lat; bit to, bg;
    int vec [5][8] = '{'{17, 2, 5, 1, 0, 5, 16, 0},
                       '{17, 2, 7, 0, 0, 7, 0,  0},
                       '{17, 2, 9, 9, 1, 6, 3,  0},
                       '{17, 2, 9, 9, 1, 4, 4,  1},
                       '{17, 2, 6, 3, 0, 1, 1,  1}};
    int ex [5][3]  = '{'{0, 0, 1}, '{0, 0, 1}, '{6, 3, 0}, '{0, 0, 1}, '{6, 3, 0}};
    for (int i = 0; i < 5; i++) begin
      run_op(vec[i][0], vec[i][1], vec[i][2], vec[i][3], vec[i][4] != 0,
             vec[i][5], vec[i][6], vec[i][7] != 0, lat, to, bg);
      n_cmp++;
      if (to || x3 !== N'(ex[i][0]) || y3 !== N'(ex[i][1]) || inf3 !== (ex[i][2] != 0)) begin
        n_bad++;
        $display("FAIL trivial_%0d: got (%0d,%0d,inf=%b), want (%0d,%0d,inf=%0d)",
                 i, x3, y3, inf3, ex[i][0], ex[i][1], ex[i][2]);
      end
      n_cmp++;
      if (lat != 3) begin n_bad++; $display("FAIL trivial_latency_%0d: got %0d, want 3", i, lat); end
    end
  endtask

  task automatic test_busy_restart;
    int dones;
    logic [N-1:0] ox, oy;
    logic oi;
    ox = '0; oy = '0; oi = 1'b1;
    @(negedge clk);
    p = 17; a = 2; x1 = 5; y1 = 1; x2 = 6; y2 = 3; inf1 = 0; inf2 = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int cyc = 0; cyc < MAX_LAT + 40; cyc++) begin
      if (done === 1'b1) begin
        dones++;
        if (dones == 1) begin ox = x3; oy = y3; oi = inf3; end
      end
      if (busy === 1'b1 && dones == 0) begin
        start = (cyc % 5 == 0);
        x1    = N'($urandom_range(0, 16));
        y2    = N'($urandom_range(0, 16));
        inf2  = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; inf2 = 1'b0;
    n_cmp++;
    if (dones != 1) begin n_bad++; $display("FAIL restart_done_count: got %0d, want 1", dones); end
    n_cmp++;
    if (ox !== N'(10) || oy !== N'(6) || oi !== 1'b0) begin
      n_bad++;
      $display("FAIL restart_result: got (%0d,%0d,inf=%b), want (10,6,inf=0)", ox, oy, oi);
    end
  endtask

  task automatic test_reset_mid;
    int lat, stale; bit to, bg;
    @(negedge clk);
    p = 17; a = 2; x1 = 5; y1 = 1; x2 = 5; y2 = 1; inf1 = 0; inf2 = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, inf3, x3, y3} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: busy=%b done=%b inf3=%b x3=%0d y3=%0d, want all 0", busy, done, inf3, x3, y3);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    stale = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) stale++;
    end
    n_cmp++;
    if (stale != 0) begin n_bad++; $display("FAIL midreset_stale: got %0d active cycles, want 0", stale); end
    run_op(17, 2, 5, 1, 0, 6, 3, 0, lat, to, bg);
    n_cmp++;
    if (to || x3 !== N'(10) || y3 !== N'(6) || inf3 !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_next: got (%0d,%0d,inf=%b), want (10,6,inf=0)", x3, y3, inf3);
    end
  endtask

  task automatic test_random;
    int m, ca, ax, ay, bx, by, rx, ry, lat, kind;
    bit ai, bi, ri, triv, to, bg;
    for (int it = 0; it < 60; it++) begin
      m  = primes[$urandom_range(0, 9)];
      ca = $urandom_range(0, m - 1);
      ax = $urandom_range(0, m - 1);
      ay = $urandom_range(0, m - 1);
      kind = $urandom_range(0, 9);
      ai = (kind == 7); bi = (kind == 8) || (kind == 9 && it % 2 == 0);
      case (kind)
        0, 1:    begin bx = ax; by = ay; end
        2:       begin bx = ax; by = md(-ay, m); end
        3:       begin ay = 0; bx = ax; by = 0; end
        default: begin bx = $urandom_range(0, m - 1); by = $urandom_range(0, m - 1); end
      endcase
      ref_point(m, ca, ax, ay, ai, bx, by, bi, rx, ry, ri, triv);
      run_op(m, ca, ax, ay, ai, bx, by, bi, lat, to, bg);
      n_cmp++;
      if (to || x3 !== N'(rx) || y3 !== N'(ry) || inf3 !== ri) begin
        n_bad++;
        $display("FAIL random_%0d: p=%0d a=%0d P1=(%0d,%0d,%b) P2=(%0d,%0d,%b) got (%0d,%0d,%b) want (%0d,%0d,%b)",
                 it, m, ca, ax, ay, ai, bx, by, bi, x3, y3, inf3, rx, ry, ri);
      end
      n_cmp++;
      if (bg || (triv && lat != 3) || lat > MAX_LAT) begin
        n_bad++;
        $display("FAIL random_timing_%0d: latency %0d busy_gap=%b, want %s", it, lat, bg,
                 triv ? "3" : "<= bound");
      end
    end
  endtask

`ifdef EC_RANGE_CHECK_EN
  task automatic test_range;
    int lat; bit to, bg;
    run_op(17, 2, 17, 1, 0, 6, 3, 0, lat, to, bg);
    n_cmp++;
    if (err !== 1'b1 || inf3 !== 1'b1 || x3 !== '0 || y3 !== '0 || lat != 3) begin
      n_bad++;
      $display("FAIL range_x1: err=%b inf3=%b x3=%0d y3=%0d lat=%0d, want err=1 inf3=1 0,0 lat=3", err, inf3, x3, y3, lat);
    end
    run_op(16, 2, 5, 1, 0, 6, 3, 0, lat, to, bg);
    n_cmp++;
    if (err !== 1'b1 || inf3 !== 1'b1) begin
      n_bad++;
      $display("FAIL range_even_p: err=%b inf3=%b, want 1,1", err, inf3);
    end
    run_op(17, 2, 5, 1, 0, 6, 3, 0, lat, to, bg);
    n_cmp++;
    if (err !== 1'b0 || x3 !== N'(10) || y3 !== N'(6) || inf3 !== 1'b0) begin
      n_bad++;
      $display("FAIL range_clear: err=%b got (%0d,%0d,%b), want err=0 (10,6,0)", err, x3, y3, inf3);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_double();
    test_add();
    test_trivial();
    test_busy_restart();
    test_reset_mid();
    test_random();
`ifdef EC_RANGE_CHECK_EN
    test_range();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
